oversampling_period_meter: RTL and testbench

//  Downstream of the oversampled ISERDES + bit detector pair; runs on CLK_PARALLEL (150MHz, 64 samples/cycle).

---
 rtl/oversampling_period_meter.sv | 128 ++++++++++++
 tb/tb_oversampling_period_meter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/oversampling_period_meter.sv
// Converts detector edge reports into fine timestamps and measures full input
// periods as the sum of the last two half-periods, in 1/64-cycle units.
module oversampling_period_meter #(
  parameter int COUNTER_BITS    = 26,
  parameter int MIN_HALF_PERIOD = 64,
  parameter int TIMEOUT_CYCLES  = 65536,
  localparam int H  = COUNTER_BITS + 6,
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic         CLK_PARALLEL,
  input  logic         RESETN,
  input  logic         CE,
  input  logic         CHANGED_FLAG,
  input  logic [5:0]   CHANGED_BIT,
  output logic         PERIOD_VALID,
  output logic [H-1:0] PERIOD_OUT,
  output logic [H-1:0] HALF_OUT,
  output logic         GLITCH,
  output logic         NO_SIGNAL
);

  typedef enum logic [1:0] {IDLE, EDGE1, RUN} state_t;

  state_t                  state_q, state_d;
  logic [COUNTER_BITS-1:0] cycle_cnt_q;
  logic [IW-1:0]           idle_q, idle_inc;
  logic [H-1:0]            ts, half, ts_prev_q, half_prev_q;
  logic                    flag, short_half, timeout;
  logic                    glitch_d, period_d, accept_d;

  // stage 1
  logic                    s1_period_q, s1_glitch_q;
  logic [H-1:0]            s1_half_q, s1_hprev_q;

  // stage 2 / outputs
  logic                    pv_q, gl_q, ns_q;
  logic [H-1:0]            po_q, ho_q;

  assign flag       = CE & CHANGED_FLAG;
  assign ts         = {cycle_cnt_q, CHANGED_BIT};
  // modular subtraction keeps half correct across counter wrap
  assign half       = ts - ts_prev_q;
  assign short_half = half < H'(MIN_HALF_PERIOD);
  assign idle_inc   = (idle_q == IW'(TIMEOUT_CYCLES)) ? idle_q : idle_q + IW'(1);
  // an edge landing in the timeout cycle takes priority
  assign timeout    = CE && !flag && (idle_inc == IW'(TIMEOUT_CYCLES));

  always_ff @(posedge CLK_PARALLEL or negedge RESETN) begin
    if (!RESETN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flag) begin
      case (state_q)
        IDLE:    state_d = EDGE1;
        EDGE1:   state_d = short_half ? EDGE1 : RUN;
        RUN:     state_d = short_half ? EDGE1 : RUN;
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    glitch_d = 1'b0;
    accept_d = 1'b0;
    period_d = 1'b0;
    if (flag && state_q != IDLE) begin
      glitch_d = short_half;
      accept_d = !short_half;
      period_d = !short_half && (state_q == RUN);
    end
  end

  always_ff @(posedge CLK_PARALLEL or negedge RESETN) begin
    if (!RESETN) begin
      cycle_cnt_q <= '0;
      idle_q      <= '0;
      ts_prev_q   <= '0;
      half_prev_q <= '0;
      s1_period_q <= 1'b0;
      s1_glitch_q <= 1'b0;
      s1_half_q   <= '0;
      s1_hprev_q  <= '0;
    end else if (CE) begin
      cycle_cnt_q <= cycle_cnt_q + COUNTER_BITS'(1);
      idle_q      <= flag ? '0 : idle_inc;
      if (flag)     ts_prev_q   <= ts;
      if (accept_d) half_prev_q <= half;
      s1_period_q <= period_d;
      s1_glitch_q <= glitch_d;
      s1_half_q   <= half;
      s1_hprev_q  <= half_prev_q;
    end
  end

  always_ff @(posedge CLK_PARALLEL or negedge RESETN) begin
    if (!RESETN) begin
      pv_q <= 1'b0;
      gl_q <= 1'b0;
      ns_q <= 1'b1;
      po_q <= '0;
      ho_q <= '0;
    end else if (CE) begin
      pv_q <= s1_period_q;
      gl_q <= s1_glitch_q;
      if (s1_period_q) begin
        po_q <= s1_half_q + s1_hprev_q;
        ho_q <= s1_half_q;
      end
      if (timeout)          ns_q <= 1'b1;
      else if (s1_period_q) ns_q <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      gl_q <= 1'b0;
    end
  end

  assign PERIOD_VALID = pv_q;
  assign GLITCH       = gl_q;
  assign NO_SIGNAL    = ns_q;
  assign PERIOD_OUT   = po_q;
  assign HALF_OUT     = ho_q;

endmodule

// File: tb/tb_oversampling_period_meter.sv
// Directed bench for oversampling_period_meter with a short counter and timeout
// so wrap and loss-of-signal scenarios stay fast.
module tb_oversampling_period_meter;
  localparam int CB = 8;
  localparam int T  = 100;
  localparam int H  = CB + 6;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         ce = 1'b1;
  logic         flag = 1'b0;
  logic [5:0]   cbit = '0;
  logic         pv, gl, ns;
  logic [H-1:0] po, ho;
  int           checks = 0;
  int           errors = 0;

  oversampling_period_meter #(.COUNTER_BITS(CB), .MIN_HALF_PERIOD(64), .TIMEOUT_CYCLES(T)) dut (
    .CLK_PARALLEL(clk), .RESETN(rstn), .CE(ce), .CHANGED_FLAG(flag), .CHANGED_BIT(cbit),
    .PERIOD_VALID(pv), .PERIOD_OUT(po), .HALF_OUT(ho), .GLITCH(gl), .NO_SIGNAL(ns)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // one flag cycle; afterwards the bench sits in the following cycle
  task automatic edge_at(input logic [5:0] b);
    flag = 1'b1; cbit = b; tick(); flag = 1'b0; cbit = '0;
  endtask

  // after return the current cycle has cycle_cnt == 0
  task automatic do_reset();
    rstn = 1'b0; ce = 1'b1; flag = 1'b0; cbit = '0;
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pv !== 1'b0) begin errors++; $display("FAIL reset_pv got %b exp 0", pv); end
    checks++; if (gl !== 1'b0) begin errors++; $display("FAIL reset_gl got %b exp 0", gl); end
    checks++; if (po !== '0) begin errors++; $display("FAIL reset_po got %0d exp 0", po); end
    checks++; if (ho !== '0) begin errors++; $display("FAIL reset_ho got %0d exp 0", ho); end
    checks++; if (ns !== 1'b1) begin errors++; $display("FAIL reset_ns got %b exp 1", ns); end
  endtask

  task automatic test_basic_period();
    do_reset();
    edge_at(0); gap(9); edge_at(0); gap(9);
    checks++; if (ns !== 1'b1) begin errors++; $display("FAIL basic_ns_before got %b exp 1", ns); end
    edge_at(0);
    checks++; if (pv !== 1'b0) begin errors++; $display("FAIL basic_lat1 got %b exp 0", pv); end
    tick();
    checks++; if (pv !== 1'b1) begin errors++; $display("FAIL basic_pv got %b exp 1", pv); end
    checks++; if (po !== 14'd1280) begin errors++; $display("FAIL basic_po got %0d exp 1280", po); end
    checks++; if (ho !== 14'd640) begin errors++; $display("FAIL basic_ho got %0d exp 640", ho); end
    checks++; if (ns !== 1'b0) begin errors++; $display("FAIL basic_ns got %b exp 0", ns); end
    tick();
    checks++; if (pv !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b exp 0", pv); end
  endtask

  task automatic test_fine_bits();
    do_reset();
    edge_at(5); gap(2); edge_at(60); gap(3); edge_at(1);
    checks++; if (pv !== 1'b0) begin errors++; $display("FAIL fine_early got %b exp 0", pv); end
    tick();
    checks++; if (pv !== 1'b1) begin errors++; $display("FAIL fine_pv got %b exp 1", pv); end
    checks++; if (po !== 14'd444) begin errors++; $display("FAIL fine_po got %0d exp 444", po); end
    checks++; if (ho !== 14'd197) begin errors++; $display("FAIL fine_ho got %0d exp 197", ho); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      edge_at(0);
      if (i >= 3) begin
        checks++; if (pv !== 1'b1 || po !== 14'd128) begin
          errors++; $display("FAIL b2b_%0d got pv=%b po=%0d exp pv=1 po=128", i, pv, po); end
      end
    end
    tick();
    checks++; if (pv !== 1'b1 || po !== 14'd128) begin
      errors++; $display("FAIL b2b_last got pv=%b po=%0d exp pv=1 po=128", pv, po); end
    tick();
    checks++; if (pv !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", pv); end
  endtask

  task automatic test_min_boundary();
    do_reset();
    edge_at(1); edge_at(0); tick();
    checks++; if (gl !== 1'b1) begin errors++; $display("FAIL min63_gl got %b exp 1", gl); end
    edge_at(0); edge_at(0); tick();
    checks++; if (pv !== 1'b1 || po !== 14'd192 || ho !== 14'd64 || gl !== 1'b0) begin
      errors++; $display("FAIL min64 got pv=%b po=%0d ho=%0d gl=%b exp 1/192/64/0", pv, po, ho, gl); end
  endtask

  task automatic test_glitch();
    do_reset();
    edge_at(50); gap(9); edge_at(50); gap(9); edge_at(50);
    edge_at(6);
    checks++; if (pv !== 1'b1 || po !== 14'd1280 || gl !== 1'b0) begin
      errors++; $display("FAIL glitch_prev got pv=%b po=%0d gl=%b exp 1/1280/0", pv, po, gl); end
    tick();
    checks++; if (gl !== 1'b1 || pv !== 1'b0) begin
      errors++; $display("FAIL glitch_pulse got gl=%b pv=%b exp 1/0", gl, pv); end
    gap(8); edge_at(6); tick();
    checks++; if (pv !== 1'b0 || gl !== 1'b0) begin
      errors++; $display("FAIL glitch_relock got pv=%b gl=%b exp 0/0", pv, gl); end
    gap(8); edge_at(6); tick();
    checks++; if (pv !== 1'b1 || po !== 14'd1280 || ho !== 14'd640) begin
      errors++; $display("FAIL glitch_after got pv=%b po=%0d ho=%0d exp 1/1280/640", pv, po, ho); end
  endtask

  task automatic test_wrap();
    do_reset();
    gap(250);
    edge_at(0); gap(3); edge_at(10); gap(2); edge_at(20); tick();
    checks++; if (pv !== 1'b1 || po !== 14'd468 || ho !== 14'd202) begin
      errors++; $display("FAIL wrap got pv=%b po=%0d ho=%0d exp 1/468/202", pv, po, ho); end
  endtask

  task automatic test_timeout();
    do_reset();
    edge_at(0); gap(9); edge_at(0); gap(9); edge_at(0);
    gap(T - 1);
    checks++; if (ns !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", ns); end
    tick();
    checks++; if (ns !== 1'b1) begin errors++; $display("FAIL to_rise got %b exp 1", ns); end
    edge_at(0); gap(9); edge_at(0); gap(9); edge_at(0); tick();
    checks++; if (ns !== 1'b0) begin errors++; $display("FAIL to_relock got %b exp 0", ns); end
    gap(T - 2);
    edge_at(0);
    checks++; if (ns !== 1'b0) begin errors++; $display("FAIL to_same_cycle got %b exp 0", ns); end
    tick();
    checks++; if (ns !== 1'b0 || pv !== 1'b1 || po !== 14'd7040 || ho !== 14'd6400) begin
      errors++; $display("FAIL to_flag_wins got ns=%b pv=%b po=%0d ho=%0d exp 0/1/7040/6400", ns, pv, po, ho); end
  endtask

  task automatic test_ce();
    do_reset();
    edge_at(0); gap(9); edge_at(0); gap(4);
    ce = 1'b0; flag = 1'b1;
    gap(50);
    flag = 1'b0; ce = 1'b1;
    gap(5); edge_at(0);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pv !== 1'b0) begin errors++; $display("FAIL ce_frozen_%0d got %b exp 0", i, pv); end
    end
    ce = 1'b1; tick();
    checks++; if (pv !== 1'b1 || po !== 14'd1280) begin
      errors++; $display("FAIL ce_period got pv=%b po=%0d exp 1/1280", pv, po); end
  endtask

  task automatic test_reset_mid_run();
    edge_at(0);
    rstn = 1'b0; #1;
    checks++; if (pv !== 1'b0 || po !== '0 || ho !== '0 || gl !== 1'b0 || ns !== 1'b1) begin
      errors++; $display("FAIL rst_mid got pv=%b po=%0d ho=%0d gl=%b ns=%b exp 0/0/0/0/1", pv, po, ho, gl, ns); end
    tick(); rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pv !== 1'b0 || gl !== 1'b0) begin
        errors++; $display("FAIL rst_nopulse_%0d got pv=%b gl=%b exp 0/0", i, pv, gl); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_period();
    test_fine_bits();
    test_back_to_back();
    test_min_boundary();
    test_glitch();
    test_wrap();
    test_timeout();
    test_ce();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
